alu_pipe: RTL and testbench
===========================

// Module: alu_pipe
// PURPOSE
// - Parametrised successor to the team's 8-bit registered ALU: WIDTH-bit, two-stage pipelined ALU with valid/ready
//   handshake on both sides, output backpressure, NZCV flags, carry-chained ADC/SBC and an iterative multiply.
// - Sits between the operand/register-file read stage and writeback; one op accepted per cycle except during MUL.
// PARAMETERS
// - WIDTH   8   operand/result width, >= 4
// PORTS
// - ck         in   1      clock, all state on posedge
// - rst_n      in   1      asynchronous active-low reset
// - in_valid   in   1      operands/opcode valid
// - in_ready   out  1      block can accept; transfer when in_valid & in_ready
// - A, B       in   WIDTH  operands
// - CTR        in   4      opcode (table below)
// - out_valid  out  1      O/flags valid; held until out_ready
// - out_ready  in   1      downstream accepts; transfer when out_valid & out_ready
// - O          out  WIDTH  result
// - FLG        out  4      {N,Z,C,V} for O
// BEHAVIOUR
// - Reset (async, rst_n=0): O=0, FLG=0, out_valid=0, carry register=0, S1 empty, FSM=EMPTY; in_ready=1 after release.
// - Opcodes: 0000 ADD, 0001 SUB(A-B), 0010 ADC(A+B+Creg), 0011 SBC(A-B-~Creg), 0100 MUL (low WIDTH bits of A*B),
//   0101 CMP (O=A, flags of A-B), 1000 AND, 1001 OR, 1010 XOR, 1011 NOT A, 1100 SHR A by 1 (zero fill),
//   1101 SHL A by 1, 1110 ROR A by 1, 1111 ROL A by 1. 0110/0111 undefined: O=0, FLG=4'b0100.
// - Flags: N=O[WIDTH-1]; Z=(O==0); C = carry-out for add ops, NOT-borrow for sub/CMP (1 when A>=B unsigned),
//   shifted-out bit for SHR/SHL/ROR/ROL, 0 for logic and MUL; V = signed overflow for add/sub/CMP, else 0.
// - Carry register Creg: loaded with C at every S1->S2 transfer; ADC/SBC read Creg at their own transfer, so
//   back-to-back ADD then ADC chains correctly with no bubble.
// - Stage S1 FSM (captured A,B,CTR):
//   EMPTY: in_ready=1; accept -> FULL (or MULT if CTR=0100, counter=0, acc=0).
//   FULL: result computed combinationally; transfers to S2 when S2 empty or S2 drained this cycle;
//         on transfer, if new input accepted same cycle -> FULL/MULT else EMPTY; in_ready=1 iff transfer occurs.
//   MULT: shift-add, one multiplier bit per cycle, WIDTH cycles; in_ready=0; then behaves as FULL with O=acc.
// - S2: O/FLG/out_valid registers; loaded on transfer; held stable while out_valid & !out_ready.
// - Latency: single-cycle ops 2 cycles accept->out_valid; MUL WIDTH+2. Throughput 1/cycle with out_ready=1.
// - Stall: out_valid & !out_ready & S1 FULL -> in_ready=0, nothing changes; no input or output lost/duplicated.
// - Simultaneous drain of S2 and refill from S1 in same cycle is required (no bubble).
// - All arithmetic modulo 2^WIDTH; shift/rotate amount fixed at 1.
// - rst_n asserted mid-MUL or mid-stall: op discarded, all state to reset values immediately.
// STRUCTURE
// - Shared package alu_pkg: opcode localparams (OP_ADD..OP_ROL), flag bit indices, S1 FSM state encoding.
// - One sub-module: alu_mul_iter (shift-add multiplier: start, A, B -> done, P low WIDTH bits, counter internal).
// - Single-cycle datapath as a function inside alu_pipe; S1/S2 registers and FSM in alu_pipe.
// TESTING (WIDTH=8)
// - Reset: rst_n=0 mid-traffic -> O=00, FLG=0, out_valid=0 same cycle; in_ready=1 next posedge after release.
// - ADD 0xFF+0x01, then ADC 0x00+0x00 back-to-back -> O=00 FLG N0Z1C1V0, then O=01 FLG=0000; outputs on cycles 2,3.
// - SUB 0x80-0x01 -> O=7F, V=1, C=1; CMP 0x05,0x07 -> O=05, N=1,C=0; ROL 0x81 -> O=03, C=1.
// - MUL 0x0D*0x0B -> O=8F after 10 cycles; in_ready=0 for 8 cycles; MUL 0x10*0x10 -> O=00, Z=1.
// - Backpressure: 4 ops streamed, out_ready low 3 cycles -> O held stable, in_ready=0 once S1 full; all 4 results
//   in order, none duplicated; random out_ready for 1000 ops vs reference model.
// - Undefined opcode 0110 -> O=00, FLG=0100; reset asserted during MUL cycle 4 -> no out_valid afterwards.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined ALU: opcodes, flag bit positions and
// the operand-stage FSM encoding.
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_ADC = 4'b0010;
  localparam logic [3:0] OP_SBC = 4'b0011;
  localparam logic [3:0] OP_MUL = 4'b0100;
  localparam logic [3:0] OP_CMP = 4'b0101;
  localparam logic [3:0] OP_AND = 4'b1000;
  localparam logic [3:0] OP_OR  = 4'b1001;
  localparam logic [3:0] OP_XOR = 4'b1010;
  localparam logic [3:0] OP_NOT = 4'b1011;
  localparam logic [3:0] OP_SHR = 4'b1100;
  localparam logic [3:0] OP_SHL = 4'b1101;
  localparam logic [3:0] OP_ROR = 4'b1110;
  localparam logic [3:0] OP_ROL = 4'b1111;

  // Flag vector is {N,Z,C,V}
  localparam int FLG_N = 3;
  localparam int FLG_Z = 2;
  localparam int FLG_C = 1;
  localparam int FLG_V = 0;

  typedef enum logic [1:0] {
    S1_EMPTY = 2'd0,
    S1_FULL  = 2'd1,
    S1_MULT  = 2'd2
  } s1_state_e;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, WIDTH cycles,
// keeps only the low WIDTH bits of the product.
module alu_mul_iter #(
  parameter int WIDTH = 8
) (
  input  logic             ck,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] p_o
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;

  // done_o marks the cycle whose clock edge adds the final partial product
  assign done_o = busy_q && (cnt_q == LAST);
  assign p_o    = acc_q;

  always_comb begin
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    if (start_i) begin
      busy_d   = 1'b1;
      cnt_d    = '0;
      acc_d    = '0;
      mcand_d  = a_i;
      mplier_d = b_i;
    end else if (busy_q) begin
      if (mplier_q[0]) acc_d = acc_q + mcand_q;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CW'(1);
      if (done_o) busy_d = 1'b0;
    end
  end

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU: S1 holds captured operands (and runs MUL), S2 holds
// the registered result and NZCV flags until downstream takes them.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             ck,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       CTR,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] O,
  output logic [3:0]       FLG,
  output logic [1:0]       dbg_state
);

  // Handshake: a transfer happens on a clock edge where valid & ready are both
  // high; valid never depends on ready, and out_valid/O/FLG hold until taken.

  s1_state_e        state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] o_q, o_d;
  logic [3:0]       flg_q, flg_d;
  logic             ov_q, ov_d;
  logic             creg_q, creg_d;

  logic             s2_free, s1_xfer, accept, mul_start, mul_done;
  logic [WIDTH-1:0] mul_p;
  logic [WIDTH+3:0] res;

  function automatic logic [WIDTH+3:0] alu_calc(
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b,
    input logic [3:0]       op,
    input logic             cin,
    input logic [WIDTH-1:0] prod
  );
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] o;
    logic             c;
    logic             v;
    sum = '0;
    r   = '0;
    c   = 1'b0;
    v   = 1'b0;
    case (op)
      OP_ADD, OP_ADC: begin
        sum = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, (op == OP_ADC) & cin};
        r   = sum[WIDTH-1:0];
        c   = sum[WIDTH];
        v   = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
      end
      // Subtraction as a + ~b + cin, so C comes out as NOT-borrow
      OP_SUB, OP_SBC, OP_CMP: begin
        sum = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, (op == OP_SBC) ? cin : 1'b1};
        r   = sum[WIDTH-1:0];
        c   = sum[WIDTH];
        v   = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
      end
      OP_MUL: r = prod;
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      OP_XOR: r = a ^ b;
      OP_NOT: r = ~a;
      OP_SHR: begin r = {1'b0, a[WIDTH-1:1]};       c = a[0];       end
      OP_SHL: begin r = {a[WIDTH-2:0], 1'b0};       c = a[WIDTH-1]; end
      OP_ROR: begin r = {a[0], a[WIDTH-1:1]};       c = a[0];       end
      OP_ROL: begin r = {a[WIDTH-2:0], a[WIDTH-1]}; c = a[WIDTH-1]; end
      default: r = '0;
    endcase
    // CMP passes A through but reports the flags of A-B
    o = (op == OP_CMP) ? a : r;
    return {r[WIDTH-1], (r == '0), c, v, o};
  endfunction

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .ck      (ck),
    .rst_n   (rst_n),
    .start_i (mul_start),
    .a_i     (A),
    .b_i     (B),
    .done_o  (mul_done),
    .p_o     (mul_p)
  );

  assign s2_free   = !ov_q || out_ready;
  assign s1_xfer   = (state_q == S1_FULL) && s2_free;
  assign in_ready  = (state_q == S1_EMPTY) || s1_xfer;
  assign accept    = in_valid && in_ready;
  assign mul_start = accept && (CTR == OP_MUL);
  assign res       = alu_calc(a_q, b_q, op_q, creg_q, mul_p);

  assign out_valid = ov_q;
  assign O         = o_q;
  assign FLG       = flg_q;
  assign dbg_state = state_q;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    case (state_q)
      S1_EMPTY, S1_FULL: begin
        if (accept) begin
          state_d = (CTR == OP_MUL) ? S1_MULT : S1_FULL;
          a_d     = A;
          b_d     = B;
          op_d    = CTR;
        end else if (s1_xfer) begin
          state_d = S1_EMPTY;
        end
      end
      S1_MULT: if (mul_done) state_d = S1_FULL;
      default: state_d = S1_EMPTY;
    endcase
  end

  always_comb begin
    o_d    = o_q;
    flg_d  = flg_q;
    ov_d   = ov_q;
    creg_d = creg_q;
    if (s1_xfer) begin
      o_d    = res[WIDTH-1:0];
      flg_d  = res[WIDTH+3:WIDTH];
      ov_d   = 1'b1;
      creg_d = res[WIDTH+FLG_C];
    end else if (out_ready) begin
      ov_d   = 1'b0;
    end
  end

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S1_EMPTY;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      o_q     <= '0;
      flg_q   <= '0;
      ov_q    <= 1'b0;
      creg_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      o_q     <= o_d;
      flg_q   <= flg_d;
      ov_q    <= ov_d;
      creg_q  <= creg_d;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Directed and randomised-backpressure bench for alu_pipe at WIDTH=8.
module tb_alu_pipe;

  localparam int W = 8;
  localparam int N_RAND = 1000;

  logic         ck = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] A, B, O;
  logic [3:0]   CTR, FLG;
  logic [1:0]   dbg_state;

  int checks = 0;
  int errors = 0;
  logic [11:0] exp_q[$];

  always #5 ck = ~ck;

  alu_pipe #(.WIDTH(W)) dut (
    .ck        (ck),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .CTR       (CTR),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .O         (O),
    .FLG       (FLG),
    .dbg_state (dbg_state)
  );

  task automatic tick;
    @(posedge ck);
    #1;
  endtask

  // Reference: integer arithmetic, result packed as {N,Z,C,V,O}
  function automatic logic [11:0] ref_alu(input logic [7:0] a, input logic [7:0] b,
                                          input logic [3:0] op, input logic cin);
    int ua, ub, sa, sb, t, st;
    logic [7:0] r, o;
    logic c, v;
    ua = a; ub = b; sa = $signed(a); sb = $signed(b);
    r = 8'h00; c = 1'b0; v = 1'b0; t = 0; st = 0;
    case (op)
      4'd0, 4'd2: begin
        t  = ua + ub + ((op == 4'd2 && cin) ? 1 : 0);
        st = sa + sb + ((op == 4'd2 && cin) ? 1 : 0);
        r = t[7:0]; c = (t > 255); v = (st > 127) || (st < -128);
      end
      4'd1, 4'd3, 4'd5: begin
        t  = ua - ub - ((op == 4'd3 && !cin) ? 1 : 0);
        st = sa - sb - ((op == 4'd3 && !cin) ? 1 : 0);
        r = t[7:0]; c = (t >= 0); v = (st > 127) || (st < -128);
      end
      4'd4: begin t = ua * ub; r = t[7:0]; end
      4'd8:  r = a & b;
      4'd9:  r = a | b;
      4'd10: r = a ^ b;
      4'd11: r = ~a;
      4'd12: begin r = a >> 1; c = a[0]; end
      4'd13: begin r = a << 1; c = a[7]; end
      4'd14: begin r = {a[0], a[7:1]}; c = a[0]; end
      4'd15: begin r = {a[6:0], a[7]}; c = a[7]; end
      default: r = 8'h00;
    endcase
    o = (op == 4'd5) ? a : r;
    return {r[7], (r == 8'h00), c, v, o};
  endfunction

  // Issue one op into an idle pipeline and wait for its result
  task automatic run_one(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op,
                         output logic [7:0] o, output logic [3:0] f,
                         output int lat, output int rdy_low);
    out_ready = 1'b1;
    A = a; B = b; CTR = op; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 1;
    rdy_low = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      if (in_ready !== 1'b1) rdy_low++;
      tick();
      lat++;
    end
    o = O;
    f = FLG;
    tick();
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; A = '0; B = '0; CTR = '0; out_ready = 1'b1;
    #2;
    checks++;
    if ({out_valid, FLG, O} !== 13'h0) begin
      errors++; $display("FAIL reset_init got %h want %h", {out_valid, FLG, O}, 13'h0);
    end
    repeat (2) @(posedge ck);
    #1 rst_n = 1'b1;
    tick();
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready got %b want 1", in_ready);
    end
    out_ready = 1'b0;
    A = 8'h12; B = 8'h34; CTR = 4'd0; in_valid = 1'b1;
    tick();
    A = 8'h01;
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1) begin
      errors++; $display("FAIL reset_traffic_valid got %b want 1", out_valid);
    end
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, FLG, O} !== 13'h0) begin
      errors++; $display("FAIL reset_mid got %h want %h", {out_valid, FLG, O}, 13'h0);
    end
    @(posedge ck);
    #1 rst_n = 1'b1;
    tick();
    checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      errors++; $display("FAIL reset_release got %b want 10", {in_ready, out_valid});
    end
    out_ready = 1'b1;
  endtask

  task automatic test_add_adc;
    out_ready = 1'b1;
    A = 8'hFF; B = 8'h01; CTR = 4'd0; in_valid = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL add_latency got %b want 0", out_valid);
    end
    A = 8'h00; B = 8'h00; CTR = 4'd2;
    tick();
    in_valid = 1'b0;
    checks++;
    if ({out_valid, FLG, O} !== {1'b1, 4'b0110, 8'h00}) begin
      errors++; $display("FAIL add_result got %h want %h", {out_valid, FLG, O}, {1'b1, 4'b0110, 8'h00});
    end
    tick();
    checks++;
    if ({out_valid, FLG, O} !== {1'b1, 4'b0000, 8'h01}) begin
      errors++; $display("FAIL adc_chain got %h want %h", {out_valid, FLG, O}, {1'b1, 4'b0000, 8'h01});
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL adc_drain got %b want 0", out_valid);
    end
  endtask

  task automatic test_ops;
    logic [7:0] va [8];
    logic [7:0] vb [8];
    logic [3:0] vop [8];
    logic [7:0] eo [8];
    logic [3:0] ef [8];
    logic [7:0] o;
    logic [3:0] f;
    int lat, rl;
    va  = '{8'h80, 8'h05, 8'h81, 8'hF0, 8'h01, 8'h7F, 8'h33, 8'h55};
    vb  = '{8'h01, 8'h07, 8'h00, 8'h3C, 8'h00, 8'h01, 8'h44, 8'h00};
    vop = '{4'd1,  4'd5,  4'd15, 4'd8,  4'd12, 4'd0,  4'd6,  4'd11};
    eo  = '{8'h7F, 8'h05, 8'h03, 8'h30, 8'h00, 8'h80, 8'h00, 8'hAA};
    ef  = '{4'b0011, 4'b1000, 4'b0010, 4'b0000, 4'b0110, 4'b1001, 4'b0100, 4'b1000};
    for (int i = 0; i < 8; i++) begin
      run_one(va[i], vb[i], vop[i], o, f, lat, rl);
      checks++;
      if (o !== eo[i]) begin
        errors++; $display("FAIL op%0d_o got %h want %h", i, o, eo[i]);
      end
      checks++;
      if (f !== ef[i]) begin
        errors++; $display("FAIL op%0d_flg got %b want %b", i, f, ef[i]);
      end
      checks++;
      if (lat != 2) begin
        errors++; $display("FAIL op%0d_latency got %0d want 2", i, lat);
      end
    end
  endtask

  task automatic test_mul;
    logic [7:0] o;
    logic [3:0] f;
    int lat, rl;
    run_one(8'h0D, 8'h0B, 4'd4, o, f, lat, rl);
    checks++;
    if ({f, o} !== {4'b1000, 8'h8F}) begin
      errors++; $display("FAIL mul_result got %h want %h", {f, o}, {4'b1000, 8'h8F});
    end
    checks++;
    if (lat != 10) begin
      errors++; $display("FAIL mul_latency got %0d want 10", lat);
    end
    checks++;
    if (rl != 8) begin
      errors++; $display("FAIL mul_in_ready_low got %0d want 8", rl);
    end
    run_one(8'h10, 8'h10, 4'd4, o, f, lat, rl);
    checks++;
    if ({f, o} !== {4'b0100, 8'h00}) begin
      errors++; $display("FAIL mul_wrap got %h want %h", {f, o}, {4'b0100, 8'h00});
    end
  endtask

  task automatic test_backpressure;
    logic [7:0] va [4];
    logic [7:0] vb [4];
    logic [3:0] vop [4];
    logic [11:0] e;
    int n_drv, n_obs, got;
    va  = '{8'h01, 8'hF0, 8'h10, 8'h55};
    vb  = '{8'h02, 8'h0F, 8'h01, 8'h00};
    vop = '{4'd0,  4'd10, 4'd9,  4'd11};
    exp_q.delete();
    exp_q.push_back({4'b0000, 8'h03});
    exp_q.push_back({4'b1000, 8'hFF});
    exp_q.push_back({4'b0000, 8'h11});
    exp_q.push_back({4'b1000, 8'hAA});
    fork
      begin
        for (int i = 0; i < 4; i++) begin
          A = va[i]; B = vb[i]; CTR = vop[i]; in_valid = 1'b1;
          n_drv = 0;
          @(negedge ck);
          while (in_ready !== 1'b1 && n_drv < 50) begin
            n_drv++;
            @(negedge ck);
          end
          @(posedge ck);
          #1;
        end
        in_valid = 1'b0;
      end
      begin
        out_ready = 1'b0;
        tick();
        tick();
        for (int k = 0; k < 3; k++) begin
          @(negedge ck);
          checks++;
          if ({out_valid, O} !== {1'b1, 8'h03}) begin
            errors++; $display("FAIL bp_hold%0d got %h want %h", k, {out_valid, O}, {1'b1, 8'h03});
          end
          checks++;
          if (in_ready !== 1'b0) begin
            errors++; $display("FAIL bp_stall%0d in_ready got %b want 0", k, in_ready);
          end
          @(posedge ck);
          #1;
        end
        out_ready = 1'b1;
        got = 0;
        n_obs = 0;
        while (got < 4 && n_obs < 50) begin
          @(negedge ck);
          n_obs++;
          if (out_valid === 1'b1 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if ({FLG, O} !== e) begin
              errors++; $display("FAIL bp_order%0d got %h want %h", got, {FLG, O}, e);
            end
            got++;
          end
        end
        checks++;
        if (got != 4) begin
          errors++; $display("FAIL bp_count got %0d want 4", got);
        end
        repeat (3) tick();
        checks++;
        if (out_valid !== 1'b0) begin
          errors++; $display("FAIL bp_no_dup got %b want 0", out_valid);
        end
      end
    join
  endtask

  task automatic test_reset_mul;
    int seen;
    out_ready = 1'b1;
    A = 8'h0D; B = 8'h0B; CTR = 4'd4; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, dbg_state} !== 3'b000) begin
      errors++; $display("FAIL mulrst_clear got %b want 000", {out_valid, dbg_state});
    end
    tick();
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (out_valid === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++; $display("FAIL mulrst_no_output got %0d want 0", seen);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL mulrst_ready got %b want 1", in_ready);
    end
  endtask

  task automatic test_random;
    logic model_c;
    logic [7:0] a, b;
    logic [3:0] op;
    logic [11:0] r, e, hold_val;
    logic hold;
    int n_drv, got, cyc;
    model_c = 1'b0;
    exp_q.delete();
    fork
      begin
        for (int i = 0; i < N_RAND; i++) begin
          a = 8'($urandom_range(0, 255));
          b = 8'($urandom_range(0, 255));
          op = 4'($urandom_range(0, 15));
          A = a; B = b; CTR = op; in_valid = 1'b1;
          n_drv = 0;
          @(negedge ck);
          while (in_ready !== 1'b1 && n_drv < 100) begin
            n_drv++;
            @(negedge ck);
          end
          checks++;
          if (n_drv >= 100) begin
            errors++; $display("FAIL rand_accept_timeout op %0d in_ready got %b want 1", i, in_ready);
            break;
          end
          r = ref_alu(a, b, op, model_c);
          model_c = r[9];
          exp_q.push_back(r);
          @(posedge ck);
          #1;
        end
        in_valid = 1'b0;
      end
      begin
        got = 0;
        cyc = 0;
        hold = 1'b0;
        hold_val = '0;
        while (got < N_RAND && cyc < 30000) begin
          out_ready = ($urandom_range(0, 3) != 0);
          @(negedge ck);
          cyc++;
          if (hold) begin
            checks++;
            if ({out_valid, FLG, O} !== {1'b1, hold_val}) begin
              errors++; $display("FAIL rand_hold got %h want %h", {out_valid, FLG, O}, {1'b1, hold_val});
            end
          end
          hold = 1'b0;
          if (out_valid === 1'b1) begin
            if (out_ready) begin
              checks++;
              if (exp_q.size() == 0) begin
                errors++; $display("FAIL rand_extra got %h want none", {FLG, O});
              end else begin
                e = exp_q.pop_front();
                if ({FLG, O} !== e) begin
                  errors++; $display("FAIL rand_result%0d got %h want %h", got, {FLG, O}, e);
                end
              end
              got++;
            end else begin
              hold = 1'b1;
              hold_val = {FLG, O};
            end
          end
          @(posedge ck);
          #1;
        end
        checks++;
        if (got != N_RAND || exp_q.size() != 0) begin
          errors++; $display("FAIL rand_count got %0d left %0d want %0d left 0", got, exp_q.size(), N_RAND);
        end
        out_ready = 1'b1;
      end
    join
  endtask

  initial begin
    test_reset();
    test_add_adc();
    test_ops();
    test_mul();
    test_backpressure();
    test_reset_mul();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
